// File: rtl/uart_frame_decoder.sv
// ASCII-hex frame decoder: ':' CMD[CMD_BYTES] DATA[0..MAX_DATA] [CHK] ';'
// Emits command, payload bytes and a held frame-end flag; aborts carry a 3-bit reason code.
module uart_frame_decoder #(
  parameter int unsigned CMD_BYTES      = 1,
  parameter int unsigned MAX_DATA       = 64,
  parameter int unsigned CHECKSUM_EN    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic                             i_master_clk,
  input  logic                             i_reset,
  input  logic [7:0]                       i_rx_data,
  input  logic                             i_rx_data_valid,
  output logic [8*CMD_BYTES-1:0]           o_cmd,
  output logic                             o_cmd_valid,
  output logic [7:0]                       o_data,
  output logic                             o_data_valid,
  output logic [$clog2(MAX_DATA+1)-1:0]    o_data_count,
  output logic                             o_end,
  output logic                             o_error,
  output logic [2:0]                       o_error_code,
  input  logic                             i_response_sent
);

  localparam int unsigned CMD_W = 8 * CMD_BYTES;
  localparam int unsigned CNT_W = $clog2(MAX_DATA + 1);
  // Byte limit in DATA: the checksum byte rides on top of the payload limit
  localparam int unsigned LIM   = MAX_DATA + ((CHECKSUM_EN != 0) ? 1 : 0);
  localparam int unsigned DC_W  = (LIM < 1) ? 1 : $clog2(LIM + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD      = 3'd1;
  localparam logic [2:0] ERR_SHORT    = 3'd2;
  localparam logic [2:0] ERR_OVERFLOW = 3'd3;
  localparam logic [2:0] ERR_CHECKSUM = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_RESTART  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD      = 2'd1,
    ST_DATA     = 2'd2,
    ST_END_WAIT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic             phase_q, phase_d;          // 0: expecting hi nibble, 1: expecting lo nibble
  logic [3:0]       nib_hi_q, nib_hi_d;
  logic [2:0]       cmd_cnt_q, cmd_cnt_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [7:0]       xor_q, xor_d;
  logic [7:0]       hold_q, hold_d;
  logic             held_v_q, held_v_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic [CNT_W-1:0] data_count_q, data_count_d;
  logic             end_q, end_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;

  logic       is_nib_c, is_start_c, is_end_c;
  logic [3:0] nib_c;
  logic [7:0] byte_c;
  logic       byte_done_c, restart_c, end_ok_c;
  logic [2:0] err_c;
  logic       in_frame_c;

  // Character classification of the incoming byte
  always_comb begin
    is_nib_c   = 1'b1;
    nib_c      = 4'd0;
    is_start_c = (i_rx_data == 8'h3A);
    is_end_c   = (i_rx_data == 8'h3B);
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      nib_c = 4'(i_rx_data - 8'h30);
    end else if (i_rx_data >= 8'h61 && i_rx_data <= 8'h66) begin
      nib_c = 4'(i_rx_data - 8'h57);
    end else if (i_rx_data >= 8'h41 && i_rx_data <= 8'h46) begin
      nib_c = 4'(i_rx_data - 8'h37);
    end else begin
      is_nib_c = 1'b0;
    end
  end

  assign byte_c     = {nib_hi_q, nib_c};
  assign in_frame_c = (state_q == ST_CMD) || (state_q == ST_DATA);

  // State register
  always_ff @(posedge i_master_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic plus abort / byte-completion decode
  always_comb begin
    state_d     = state_q;
    err_c       = ERR_NONE;
    byte_done_c = 1'b0;
    restart_c   = 1'b0;
    end_ok_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_data_valid && is_start_c) begin
          state_d   = ST_CMD;
          restart_c = 1'b1;
        end
      end
      ST_CMD, ST_DATA: begin
        if (i_rx_data_valid) begin
          if (is_start_c) begin
            err_c     = ERR_RESTART;
            restart_c = 1'b1;
            state_d   = ST_CMD;
          end else if (is_nib_c) begin
            if (phase_q) begin
              byte_done_c = 1'b1;
              if (state_q == ST_CMD) begin
                if (cmd_cnt_q == 3'(CMD_BYTES - 1)) state_d = ST_DATA;
              end else if (dcnt_q == DC_W'(LIM)) begin
                err_c = ERR_OVERFLOW;
              end
            end
          end else if (is_end_c) begin
            if (state_q == ST_CMD || phase_q) begin
              err_c = ERR_SHORT;
            end else if (CHECKSUM_EN != 0 && !(held_v_q && hold_q == xor_q)) begin
              err_c = ERR_CHECKSUM;
            end else begin
              end_ok_c = 1'b1;
              state_d  = ST_END_WAIT;
            end
          end else begin
            err_c = ERR_BAD;
          end
        end else if (TIMEOUT_CYCLES != 0 && tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_c = ERR_TIMEOUT;
        end
        if (err_c != ERR_NONE && err_c != ERR_RESTART) state_d = ST_IDLE;
      end
      ST_END_WAIT: begin
        if (i_response_sent) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    phase_d      = phase_q;
    nib_hi_d     = nib_hi_q;
    cmd_cnt_d    = cmd_cnt_q;
    dcnt_d       = dcnt_q;
    xor_d        = xor_q;
    hold_d       = hold_q;
    held_v_d     = held_v_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    data_count_d = data_count_q;
    end_d        = end_q;
    err_code_d   = err_code_q;
    cmd_valid_d  = 1'b0;
    data_valid_d = 1'b0;
    error_d      = 1'b0;

    // Inter-character timer only runs inside a frame
    if (in_frame_c && !i_rx_data_valid) tmo_d = tmo_q + 1'b1;
    else                                tmo_d = '0;

    if (restart_c) begin
      phase_d      = 1'b0;
      cmd_cnt_d    = 3'd0;
      dcnt_d       = '0;
      xor_d        = 8'h00;
      held_v_d     = 1'b0;
      data_count_d = '0;
    end else if (i_rx_data_valid && is_nib_c && in_frame_c) begin
      if (!phase_q) begin
        nib_hi_d = nib_c;
        phase_d  = 1'b1;
      end else begin
        phase_d  = 1'b0;
      end
    end

    if (byte_done_c) begin
      if (state_q == ST_CMD) begin
        cmd_d     = (cmd_q << 8) | CMD_W'(byte_c);
        xor_d     = xor_q ^ byte_c;
        cmd_cnt_d = cmd_cnt_q + 3'd1;
        if (state_d == ST_DATA) cmd_valid_d = 1'b1;
      end else if (err_c == ERR_NONE) begin
        dcnt_d = dcnt_q + DC_W'(1);
        if (CHECKSUM_EN == 0) begin
          data_d       = byte_c;
          data_valid_d = 1'b1;
        end else begin
          // One-byte delay so the final byte before ';' can be kept as the checksum
          hold_d   = byte_c;
          held_v_d = 1'b1;
          if (held_v_q) begin
            data_d       = hold_q;
            data_valid_d = 1'b1;
            xor_d        = xor_q ^ hold_q;
          end
        end
        if (data_valid_d && data_count_q != CNT_W'(MAX_DATA)) begin
          data_count_d = data_count_q + CNT_W'(1);
        end
      end
    end

    if (end_ok_c) begin
      end_d = 1'b1;
    end else if (state_q == ST_END_WAIT && i_response_sent) begin
      end_d = 1'b0;
    end

    if (err_c != ERR_NONE) begin
      error_d    = 1'b1;
      err_code_d = err_c;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      phase_q      <= 1'b0;
      nib_hi_q     <= 4'd0;
      cmd_cnt_q    <= 3'd0;
      dcnt_q       <= '0;
      xor_q        <= 8'h00;
      hold_q       <= 8'h00;
      held_v_q     <= 1'b0;
      tmo_q        <= '0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      data_count_q <= '0;
      end_q        <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      phase_q      <= phase_d;
      nib_hi_q     <= nib_hi_d;
      cmd_cnt_q    <= cmd_cnt_d;
      dcnt_q       <= dcnt_d;
      xor_q        <= xor_d;
      hold_q       <= hold_d;
      held_v_q     <= held_v_d;
      tmo_q        <= tmo_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      data_count_q <= data_count_d;
      end_q        <= end_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
    end
  end

  assign o_cmd        = cmd_q;
  assign o_cmd_valid  = cmd_valid_q;
  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;
  assign o_data_count = data_count_q;
  assign o_end        = end_q;
  assign o_error      = error_q;
  assign o_error_code = err_code_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder across four parameter sets sharing one stimulus bus.
module tb_uart_frame_decoder;

  localparam int K_CMD  = 0;
  localparam int K_DATA = 1;
  localparam int K_END  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_v;
  logic       rsp;
  int         sel;
  logic [3:0] rxv_i, rsp_i;

  // Per-instance outputs
  logic [7:0]  c0_cmd, c1_cmd, c3_cmd;
  logic [15:0] c2_cmd;
  logic        c0_cv, c1_cv, c2_cv, c3_cv;
  logic [7:0]  c0_d, c1_d, c2_d, c3_d;
  logic        c0_dv, c1_dv, c2_dv, c3_dv;
  logic [6:0]  c0_n, c1_n, c2_n;
  logic [1:0]  c3_n;
  logic        c0_end, c1_end, c2_end, c3_end;
  logic        c0_err, c1_err, c2_err, c3_err;
  logic [2:0]  c0_code, c1_code, c2_code, c3_code;

  // Outputs of the selected instance
  logic [15:0] m_cmd;
  logic        m_cv, m_dv, m_end, m_err;
  logic [7:0]  m_d;
  logic [6:0]  m_n;
  logic [2:0]  m_code;
  logic        end_prev = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    rxv_i = rx_v ? (4'b0001 << sel) : 4'b0000;
    rsp_i = rsp  ? (4'b0001 << sel) : 4'b0000;
  end

  always_comb begin
    case (sel)
      1: begin m_cmd = 16'(c1_cmd); m_cv = c1_cv; m_d = c1_d; m_dv = c1_dv; m_n = c1_n;     m_end = c1_end; m_err = c1_err; m_code = c1_code; end
      2: begin m_cmd = c2_cmd;      m_cv = c2_cv; m_d = c2_d; m_dv = c2_dv; m_n = c2_n;     m_end = c2_end; m_err = c2_err; m_code = c2_code; end
      3: begin m_cmd = 16'(c3_cmd); m_cv = c3_cv; m_d = c3_d; m_dv = c3_dv; m_n = 7'(c3_n); m_end = c3_end; m_err = c3_err; m_code = c3_code; end
      default: begin m_cmd = 16'(c0_cmd); m_cv = c0_cv; m_d = c0_d; m_dv = c0_dv; m_n = c0_n; m_end = c0_end; m_err = c0_err; m_code = c0_code; end
    endcase
  end

  uart_frame_decoder #(.CMD_BYTES(1), .MAX_DATA(64), .CHECKSUM_EN(0), .TIMEOUT_CYCLES(100)) u0 (
    .i_master_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_data_valid(rxv_i[0]),
    .o_cmd(c0_cmd), .o_cmd_valid(c0_cv), .o_data(c0_d), .o_data_valid(c0_dv),
    .o_data_count(c0_n), .o_end(c0_end), .o_error(c0_err), .o_error_code(c0_code),
    .i_response_sent(rsp_i[0]));

  uart_frame_decoder #(.CMD_BYTES(1), .MAX_DATA(64), .CHECKSUM_EN(1), .TIMEOUT_CYCLES(100)) u1 (
    .i_master_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_data_valid(rxv_i[1]),
    .o_cmd(c1_cmd), .o_cmd_valid(c1_cv), .o_data(c1_d), .o_data_valid(c1_dv),
    .o_data_count(c1_n), .o_end(c1_end), .o_error(c1_err), .o_error_code(c1_code),
    .i_response_sent(rsp_i[1]));

  uart_frame_decoder #(.CMD_BYTES(2), .MAX_DATA(64), .CHECKSUM_EN(0), .TIMEOUT_CYCLES(100)) u2 (
    .i_master_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_data_valid(rxv_i[2]),
    .o_cmd(c2_cmd), .o_cmd_valid(c2_cv), .o_data(c2_d), .o_data_valid(c2_dv),
    .o_data_count(c2_n), .o_end(c2_end), .o_error(c2_err), .o_error_code(c2_code),
    .i_response_sent(rsp_i[2]));

  uart_frame_decoder #(.CMD_BYTES(1), .MAX_DATA(2), .CHECKSUM_EN(0), .TIMEOUT_CYCLES(100)) u3 (
    .i_master_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_data_valid(rxv_i[3]),
    .o_cmd(c3_cmd), .o_cmd_valid(c3_cv), .o_data(c3_d), .o_data_valid(c3_dv),
    .o_data_count(c3_n), .o_end(c3_end), .o_error(c3_err), .o_error_code(c3_code),
    .i_response_sent(rsp_i[3]));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input int val, input string tag);
    ev_t e;
    if (exp_q.size() == 0) begin
      e.kind = -1;
      e.val  = -1;
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_kind"}, kind, e.kind);
    check({tag, "_val"}, val, e.val);
  endtask

  // Output monitor: every observed event is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (m_cv)               sb_pop(K_CMD,  int'(m_cmd),  "cmd");
      if (m_dv)               sb_pop(K_DATA, int'(m_d),    "data");
      if (m_err)              sb_pop(K_ERR,  int'(m_code), "err");
      if (m_end && !end_prev) sb_pop(K_END,  int'(m_n),    "end");
    end
    end_prev <= m_end;
  end

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      rx_data = s[i];
      rx_v    = 1'b1;
      @(posedge clk); #1;
      rx_v    = 1'b0;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic respond(input string tag);
    @(posedge clk); #1;
    check({tag, "_end_hi"}, int'(m_end), 1);
    rsp = 1'b1;
    @(posedge clk); #1;
    rsp = 1'b0;
    check({tag, "_end_lo"}, int'(m_end), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    rst = 1'b1; rx_v = 1'b0; rsp = 1'b0; rx_data = 8'h00; sel = 0;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      check("rst_cmd", int'(m_cmd), 0);
      check("rst_flags", int'({m_cv, m_dv, m_end, m_err, m_code}), 0);
      check("rst_data_cnt", int'({m_d, m_n}), 0);
    end
    sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic frame
    push(K_CMD, 'h12); push(K_DATA, 'hAB); push(K_DATA, 'h34); push(K_END, 2);
    send_str(":12AB34;");
    drain("basic");
    check("basic_count", int'(m_n), 2);
    respond("basic");

    // END_WAIT ignores a complete new frame
    push(K_CMD, 'h77); push(K_END, 0);
    send_str(":77;");
    drain("ew_first");
    send_str(":22;");
    drain("ew_ignore");
    check("ew_cmd_kept", int'(m_cmd), 'h77);
    respond("ew");

    // BAD character, then a clean frame; error code stays held
    push(K_CMD, 'h12); push(K_ERR, 1);
    send_str(":12AG");
    drain("bad");
    check("bad_code", int'(m_code), 1);
    push(K_CMD, 'h05); push(K_END, 0);
    send_str(":05;");
    drain("after_bad");
    check("code_held", int'(m_code), 1);
    respond("after_bad");

    // START inside a frame restarts
    push(K_CMD, 'h12); push(K_ERR, 6); push(K_CMD, 'h34); push(K_END, 0);
    send_str(":12A:34;");
    drain("restart");
    respond("restart");

    // END on odd nibble
    push(K_CMD, 'h12); push(K_ERR, 2);
    send_str(":123;");
    drain("odd_end");

    // Timeout: nothing before 100 idle cycles, error afterwards
    push(K_ERR, 5);
    send_str(":1");
    repeat (85) @(posedge clk);
    #1;
    check("tmo_not_yet", exp_q.size(), 1);
    repeat (25) @(posedge clk);
    #1;
    check("tmo_fired", exp_q.size(), 0);
    check("tmo_code", int'(m_code), 5);

    // Checksum variant
    sel = 1;
    push(K_CMD, 'h12); push(K_DATA, 'hAB); push(K_DATA, 'h34); push(K_END, 2);
    send_str(":12aB348D;");
    drain("chk_ok");
    check("chk_count", int'(m_n), 2);
    respond("chk_ok");
    push(K_CMD, 'h12); push(K_DATA, 'hAB); push(K_DATA, 'h34); push(K_ERR, 4);
    send_str(":12AB3400;");
    drain("chk_bad");
    check("chk_bad_noend", int'(m_end), 0);
    push(K_CMD, 'h12); push(K_ERR, 4);
    send_str(":12;");
    drain("chk_missing");

    // Two-byte command
    sel = 2;
    push(K_CMD, 'hBEEF); push(K_END, 0);
    send_str(":BEEF;");
    drain("cmd2");
    check("cmd2_val", int'(m_cmd), 'hBEEF);
    respond("cmd2");
    push(K_ERR, 2);
    send_str(":BE;");
    drain("cmd2_short");

    // Payload limit of two bytes
    sel = 3;
    push(K_CMD, 'h01); push(K_DATA, 'hAA); push(K_DATA, 'hBB); push(K_ERR, 3);
    send_str(":01AABBCC;");
    drain("ovf");
    check("ovf_noend", int'(m_end), 0);
    check("ovf_count", int'(m_n), 2);
    push(K_CMD, 'h01); push(K_DATA, 'hAA); push(K_DATA, 'hBB); push(K_END, 2);
    send_str(":01AABB;");
    drain("at_limit");
    respond("at_limit");

    repeat (4) @(posedge clk);
    #1;
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Parametrised successor to the single-byte-command hex UART decoder.
- Consumes the received byte stream from UART_RX and decodes ASCII-hex frames of the form ':' CMD[CMD_BYTES] DATA[0..MAX_DATA] [CHK] ';'.
- Emits the command, the data bytes and a frame-end handshake toward the MCU controller.
- Adds features the previous generation lacked: multi-byte commands, an optional XOR checksum, a payload length limit, an inter-character timeout and coded error reporting.

Parameters:
- CMD_BYTES, 1: number of command bytes per frame (1..4).
- MAX_DATA, 64: maximum payload bytes, excluding the checksum byte.
- CHECKSUM_EN, 0: 1 means the last byte before ';' is an XOR checksum.
- TIMEOUT_CYCLES, 120000: maximum i_master_clk cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- i_master_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte from UART_RX.
- i_rx_data_valid  in  1  one-cycle strobe qualifying i_rx_data.
- o_cmd  out  8*CMD_BYTES  command; the first received byte sits in the MSBs.
- o_cmd_valid  out  1  one-cycle pulse when the full command has been decoded.
- o_data  out  8  payload byte.
- o_data_valid  out  1  one-cycle pulse per payload byte.
- o_data_count  out  $clog2(MAX_DATA+1)  payload bytes emitted in the current frame.
- o_end  out  1  level; the frame terminated successfully; held until i_response_sent.
- o_error  out  1  one-cycle pulse; the frame was aborted.
- o_error_code  out  3  reason for the abort; valid with o_error and held until the next error.
- i_response_sent  in  1  pulse from the controller; releases o_end.

Behaviour:
- Reset: all outputs are 0, the state is IDLE, all counters are cleared. Reset mid-frame discards the frame without asserting o_error.
- Character classes:
  - '0'-'9', 'a'-'f', 'A'-'F' are nibbles.
  - ':' is START and ';' is END.
  - Any other byte is BAD.
- Only cycles with i_rx_data_valid are considered.
- States: IDLE, CMD, DATA, END_WAIT. A nibble-phase bit (hi/lo) is kept in CMD and DATA.
- IDLE:
  - START moves to CMD: phase=hi, byte counters=0, xor=0, o_data_count=0.
  - Every other character is ignored.
- CMD:
  - A hi nibble is stored.
  - A lo nibble completes a byte, which is shifted into o_cmd and XORed into xor.
  - After CMD_BYTES bytes: o_cmd_valid pulses, then the state moves to DATA.
- DATA, CHECKSUM_EN=0:
  - Each completed byte is emitted on o_data with an o_data_valid pulse, and o_data_count increments.
- DATA, CHECKSUM_EN=1:
  - A one-byte hold register delays emission.
  - On completion of byte n, the held byte n-1 is emitted and xor is updated with it; byte n becomes the held byte.
  - On END, the held byte is the checksum.
- Latency: o_cmd_valid and o_data_valid rise exactly 1 cycle after the i_rx_data_valid of the completing lo nibble.
- END in DATA with phase=hi:
  - CHECKSUM_EN=0: o_end=1, state moves to END_WAIT.
  - CHECKSUM_EN=1: a held byte is required and must equal xor; otherwise abort with code 4.
- END_WAIT:
  - All rx bytes are ignored, including START.
  - i_response_sent drops o_end in the next cycle and returns the state to IDLE.
  - i_response_sent outside END_WAIT is ignored.
- Aborts: state moves to IDLE, o_error pulses 1 cycle after the offending byte, and o_error_code is set.
  - 1: BAD character in CMD or DATA.
  - 2: END on an odd nibble, or END in CMD (short frame).
  - 3: payload exceeds MAX_DATA. The check is made on completion of byte MAX_DATA+1, counting the checksum byte as extra when CHECKSUM_EN=1.
  - 4: checksum mismatch, or checksum missing.
  - 5: timeout. The counter reloads on every valid byte in CMD or DATA and expires after TIMEOUT_CYCLES cycles without one.
  - 6: START inside CMD or DATA. o_error pulses and the block immediately restarts a new frame in CMD; it does not return to IDLE.
- Data already emitted before an abort is not retracted. The controller uses o_error to discard it.
- A byte valid on the same cycle as timeout expiry wins: the timer reloads and the byte is processed.
- o_data_count saturates at MAX_DATA and is cleared on START.

Test Plan:
- CMD_BYTES=1, CHECKSUM_EN=0, stream ":12AB34;" -> o_cmd=0x12 (1 pulse), o_data 0xAB then 0x34, o_end=1 with o_data_count=2; i_response_sent -> o_end=0 next cycle, state IDLE.
- CHECKSUM_EN=1, ":12aB348D;" -> data 0xAB,0x34 only, o_end=1; ":12AB3400;" -> o_error, code 4, no o_end.
- CMD_BYTES=2, ":BEEF;" -> o_cmd=0xBEEF, no data, o_end=1; ":BE;" -> o_error, code 2.
- ":12AG" -> o_error, code 1; then ":05;" -> o_cmd=0x05, o_end=1. Also ":12A:34;" -> code 6, then o_cmd=0x34, o_end.
- MAX_DATA=2, ":01AABBCC;" -> 0xAA,0xBB emitted, o_error with code 3 after "CC", the trailing ';' ignored in IDLE.
- TIMEOUT_CYCLES=100, ":1" then idle 100 cycles -> o_error, code 5; during END_WAIT, send ":22;" -> ignored, o_cmd unchanged.
